req_arbiter8: RTL

- Sequential 8-requester arbiter built around a priority pick. Each cycle with no active grant, it selects one requester. It holds a one-hot grant until that requester releases or a hold timeout expires.
- Provides a binary grant index alongside the one-hot grant.
- Sits in front of any shared resource (bus, port, engine) that the encoder-based select logic steers.

---
 rtl/arb_pkg.sv | 19 +
 rtl/prio_pick8.sv | 36 +++
 rtl/req_arbiter8.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 8-requester arbiter: sizes, FSM state encoding
// and the index-to-one-hot helper.
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // One-hot vector with only bit 'idx' set.
  function automatic logic [N_REQ-1:0] onehot_of(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/prio_pick8.sv
// Combinational descending priority picker over 8 eligible lines.
// Ports:
//   eligible [7:0] : candidate lines
//   start    [2:0] : highest-priority index in rotated mode
//   rr_mode        : 1 = search descending from start with wrap, 0 = index 7 first
//   any            : some eligible line is set
//   idx      [2:0] : winning index (0 when any=0)
module prio_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] eligible,
  input  logic [IDX_W-1:0] start,
  input  logic             rr_mode,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] first;
  logic [IDX_W-1:0] cand;

  // Walk from the lowest-priority offset up to 'first'; the last hit wins.
  always_comb begin
    first = rr_mode ? start : IDX_W'(N_REQ - 1);
    any   = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      cand = first - IDX_W'(i);
      if (eligible[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/req_arbiter8.sv
// 8-requester grant-and-hold arbiter with hold timeout and timed-out masking.
// Optional macro ARB_ROUND_ROBIN_EN: rotate priority from the last granted index.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   en             : allows new grants from IDLE
//   req      [7:0] : request lines, held high for the whole transaction
//   gnt      [7:0] : one-hot grant
//   gnt_idx  [2:0] : binary grant index (0 when no grant)
//   gnt_valid      : grant active
//   timeout        : one-cycle pulse when a grant is force-released
module req_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam bit               TO_EN     = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0] block_mask_q, block_mask_d;

  logic [N_REQ-1:0] eligible;
  logic [IDX_W-1:0] pick_start;
  logic             pick_rr;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;

  assign eligible = req & ~block_mask_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  // Search starts just below the last winner, so reset ptr=0 starts at 7.
  assign pick_start = ptr_q - IDX_W'(1);
  assign pick_rr    = 1'b1;
`else
  assign pick_start = IDX_W'(N_REQ - 1);
  assign pick_rr    = 1'b0;
`endif

  prio_pick8 u_pick (
    .eligible (eligible),
    .start    (pick_start),
    .rr_mode  (pick_rr),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_valid_d  = gnt_valid_q;
    timeout_d    = 1'b0;
    hold_cnt_d   = hold_cnt_q;
    // A requester's block lifts as soon as it drops its request.
    block_mask_d = block_mask_q & req;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d        = ptr_q;
`endif

    case (state_q)
      IDLE: begin
        if (en && pick_any) begin
          state_d     = GRANT;
          gnt_d       = onehot_of(pick_idx);
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_d       = pick_idx;
`endif
        end
      end

      GRANT: begin
        if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
        // Release wins over a coincident timeout: no pulse, no mask.
        if (!req[gnt_idx_q]) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
        end else if (TO_EN && (hold_cnt_q == HOLD_LAST)) begin
          state_d      = IDLE;
          gnt_d        = '0;
          gnt_idx_d    = '0;
          gnt_valid_d  = 1'b0;
          timeout_d    = 1'b1;
          block_mask_d = block_mask_d | onehot_of(gnt_idx_q);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      gnt_idx_q    <= '0;
      gnt_valid_q  <= 1'b0;
      timeout_q    <= 1'b0;
      hold_cnt_q   <= '0;
      block_mask_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_valid_q  <= gnt_valid_d;
      timeout_q    <= timeout_d;
      hold_cnt_q   <= hold_cnt_d;
      block_mask_q <= block_mask_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule
